// File: rtl/data_mem_ctrl.sv
// Data-memory controller for the RV32I load/store path: word RAM with byte/half/word
// lanes, sign extension, range/alignment checking and a bank of memory-mapped LED registers.
module data_mem_ctrl #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h2000,
    parameter int          NUM_LED     = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          addr,
    input  logic [31:0]          write_data,
    input  logic                 memwrite,
    input  logic                 memread,
    input  logic [3:0]           sign_mask,
    output logic [31:0]          read_data,
    output logic                 clk_stall,
    output logic [8*NUM_LED-1:0] led,
    output logic                 access_err
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam int          CW         = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;
    localparam logic [31:0] RAM_BYTES  = 32'(4 * DEPTH_WORDS);
    localparam logic [31:0] MMIO_BYTES = 32'(4 * NUM_LED);

    typedef enum logic [2:0] {IDLE, FETCH, READ, WRITE, MMIO} state_t;

    state_t        state;
    logic          settle;
    logic [31:0]   addr_r;
    logic [31:0]   wdata_r;
    logic [3:0]    mask_r;
    logic          is_load;
    logic [31:0]   word_buf;
    logic [31:0]   ram_q;
    logic [31:0]   ram [DEPTH_WORDS];

    logic          size_ok, misaligned, in_ram, in_mmio, req, reject;
    logic [AW-1:0] idx;
    logic [CW-1:0] ch;
    logic [4:0]    b_off, h_off;
    logic [7:0]    lane_b, led_sel;
    logic [15:0]   lane_h;
    logic [31:0]   load_val, store_val;

    // Request qualification uses the live inputs so a reject costs no stall cycle.
    always_comb begin
        size_ok    = (sign_mask[2:0] == 3'b001) || (sign_mask[2:0] == 3'b011) ||
                     (sign_mask[2:0] == 3'b111);
        misaligned = ((sign_mask[2:0] == 3'b011) && addr[0]) ||
                     ((sign_mask[2:0] == 3'b111) && (addr[1:0] != 2'b00));
        in_ram     = addr < RAM_BYTES;
        in_mmio    = (addr >= MMIO_BASE) && ((addr - MMIO_BASE) < MMIO_BYTES);
        req        = memread | memwrite;
        reject     = !size_ok || misaligned || !(in_ram || in_mmio);
    end

    assign idx   = addr_r[AW+1:2];
    assign ch    = CW'((addr_r - MMIO_BASE) >> 2);
    assign b_off = {addr_r[1:0], 3'b000};
    assign h_off = {addr_r[1], 4'b0000};

    always_comb begin
        lane_b = word_buf[b_off +: 8];
        lane_h = word_buf[h_off +: 16];
        case (mask_r[2:0])
            3'b001:  load_val = {{24{mask_r[3] & lane_b[7]}}, lane_b};
            3'b011:  load_val = {{16{mask_r[3] & lane_h[15]}}, lane_h};
            default: load_val = word_buf;
        endcase
        store_val = word_buf;
        case (mask_r[2:0])
            3'b001:  store_val[b_off +: 8]  = wdata_r[7:0];
            3'b011:  store_val[h_off +: 16] = wdata_r[15:0];
            default: store_val = wdata_r;
        endcase
        led_sel = 8'h00;
        for (int n = 0; n < NUM_LED; n++) begin
            if (ch == CW'(n)) led_sel = led[8*n +: 8];
        end
    end

    // RAM is not reset; a reset during WRITE forces state to IDLE so the store never lands.
    always_ff @(posedge clk) begin
        if (state == WRITE) ram[idx] <= store_val;
        ram_q <= ram[idx];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            settle     <= 1'b0;
            clk_stall  <= 1'b0;
            read_data  <= '0;
            led        <= '0;
            access_err <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= '0;
            mask_r     <= '0;
            is_load    <= 1'b0;
            word_buf   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    addr_r     <= addr;
                    wdata_r    <= write_data;
                    mask_r     <= sign_mask;
                    is_load    <= memread;
                    access_err <= 1'b0;
                    settle     <= 1'b1;
                    if (req) begin
                        if (reject) begin
                            access_err <= 1'b1;
                            if (memread) read_data <= '0;
                        end else if (in_mmio) begin
                            state     <= MMIO;
                            clk_stall <= 1'b1;
                        end else begin
                            state     <= FETCH;
                            clk_stall <= 1'b1;
                        end
                    end
                end
                // First FETCH cycle lets the registered RAM read port catch up with idx.
                FETCH: begin
                    settle <= 1'b0;
                    if (!settle) begin
                        word_buf <= ram_q;
                        state    <= is_load ? READ : WRITE;
                    end
                end
                READ: begin
                    read_data <= load_val;
                    clk_stall <= 1'b0;
                    state     <= IDLE;
                end
                WRITE: begin
                    clk_stall <= 1'b0;
                    state     <= IDLE;
                end
                MMIO: begin
                    settle <= 1'b0;
                    if (!settle) begin
                        if (is_load) begin
                            read_data <= {24'h0, led_sel};
                        end else begin
                            for (int n = 0; n < NUM_LED; n++) begin
                                if (ch == CW'(n)) led[8*n +: 8] <= wdata_r[7:0];
                            end
                        end
                        clk_stall <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed table-driven bench for data_mem_ctrl (NUM_LED=2) plus a reset-during-store sequence.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] write_data = '0;
    logic        memwrite = 1'b0;
    logic        memread = 1'b0;
    logic [3:0]  sign_mask = '0;
    logic [31:0] read_data;
    logic        clk_stall;
    logic [15:0] led;
    logic        access_err;

    int n_vec  = 0;
    int n_fail = 0;

    data_mem_ctrl #(.DEPTH_WORDS(1024), .MMIO_BASE(32'h2000), .NUM_LED(2), .INIT_FILE("")) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .write_data (write_data),
        .memwrite   (memwrite),
        .memread    (memread),
        .sign_mask  (sign_mask),
        .read_data  (read_data),
        .clk_stall  (clk_stall),
        .led        (led),
        .access_err (access_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          op;      // 0 store, 1 load, 2 both
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  sm;
        int          stalls;
        logic        err;
        logic [31:0] rd;
        logic [15:0] led_v;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_access(input int op, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] sm, output int stalls, output logic err);
        @(negedge clk);
        addr       = a;
        write_data = wd;
        sign_mask  = sm;
        memread    = (op != 0);
        memwrite   = (op != 1);
        @(posedge clk);
        #1;
        memread  = 1'b0;
        memwrite = 1'b0;
        err      = access_err;
        stalls   = 0;
        while (clk_stall && stalls < 20) begin
            stalls++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int   st;
        logic e;

        vq.push_back('{0, 32'h20,   32'h0000_0000, 4'b0111, 3, 1'b0, 32'h0000_0000, 16'h0000});
        vq.push_back('{0, 32'h10,   32'hDEAD_BEEF, 4'b0111, 3, 1'b0, 32'h0000_0000, 16'h0000});
        vq.push_back('{1, 32'h10,   32'h0,         4'b0111, 3, 1'b0, 32'hDEAD_BEEF, 16'h0000});
        vq.push_back('{0, 32'h13,   32'h0000_0080, 4'b0001, 3, 1'b0, 32'hDEAD_BEEF, 16'h0000});
        vq.push_back('{1, 32'h13,   32'h0,         4'b1001, 3, 1'b0, 32'hFFFF_FF80, 16'h0000});
        vq.push_back('{1, 32'h13,   32'h0,         4'b0001, 3, 1'b0, 32'h0000_0080, 16'h0000});
        vq.push_back('{1, 32'h10,   32'h0,         4'b0111, 3, 1'b0, 32'h80AD_BEEF, 16'h0000});
        vq.push_back('{0, 32'h22,   32'h0000_8001, 4'b0011, 3, 1'b0, 32'h80AD_BEEF, 16'h0000});
        vq.push_back('{1, 32'h22,   32'h0,         4'b1011, 3, 1'b0, 32'hFFFF_8001, 16'h0000});
        vq.push_back('{1, 32'h22,   32'h0,         4'b0011, 3, 1'b0, 32'h0000_8001, 16'h0000});
        vq.push_back('{1, 32'h20,   32'h0,         4'b0111, 3, 1'b0, 32'h8001_0000, 16'h0000});
        vq.push_back('{1, 32'h23,   32'h0,         4'b1001, 3, 1'b0, 32'hFFFF_FF80, 16'h0000});
        vq.push_back('{1, 32'h22,   32'h0,         4'b1001, 3, 1'b0, 32'h0000_0001, 16'h0000});
        vq.push_back('{1, 32'h20,   32'h0,         4'b1011, 3, 1'b0, 32'h0000_0000, 16'h0000});
        vq.push_back('{0, 32'hFFC,  32'hCAFE_F00D, 4'b0111, 3, 1'b0, 32'h0000_0000, 16'h0000});
        vq.push_back('{1, 32'hFFC,  32'h0,         4'b0111, 3, 1'b0, 32'hCAFE_F00D, 16'h0000});
        vq.push_back('{1, 32'hFFE,  32'h0,         4'b1011, 3, 1'b0, 32'hFFFF_CAFE, 16'h0000});
        vq.push_back('{0, 32'h2004, 32'h0000_00A5, 4'b0001, 2, 1'b0, 32'hFFFF_CAFE, 16'hA500});
        vq.push_back('{1, 32'h2004, 32'h0,         4'b0111, 2, 1'b0, 32'h0000_00A5, 16'hA500});
        vq.push_back('{0, 32'h2000, 32'h1234_5666, 4'b0111, 2, 1'b0, 32'h0000_00A5, 16'hA566});
        vq.push_back('{1, 32'h2000, 32'h0,         4'b0001, 2, 1'b0, 32'h0000_0066, 16'hA566});
        vq.push_back('{0, 32'h23,   32'h0000_BEEF, 4'b0011, 0, 1'b1, 32'h0000_0066, 16'hA566});
        vq.push_back('{1, 32'h11,   32'h0,         4'b0111, 0, 1'b1, 32'h0000_0000, 16'hA566});
        vq.push_back('{1, 32'h10,   32'h0,         4'b0111, 3, 1'b0, 32'h80AD_BEEF, 16'hA566});
        vq.push_back('{1, 32'h1000, 32'h0,         4'b0111, 0, 1'b1, 32'h0000_0000, 16'hA566});
        vq.push_back('{1, 32'h10,   32'h0,         4'b0111, 3, 1'b0, 32'h80AD_BEEF, 16'hA566});
        vq.push_back('{1, 32'h10,   32'h0,         4'b0101, 0, 1'b1, 32'h0000_0000, 16'hA566});
        vq.push_back('{1, 32'h2008, 32'h0,         4'b0111, 0, 1'b1, 32'h0000_0000, 16'hA566});
        vq.push_back('{2, 32'h10,   32'h1111_1111, 4'b0111, 3, 1'b0, 32'h80AD_BEEF, 16'hA566});
        vq.push_back('{1, 32'h10,   32'h0,         4'b0111, 3, 1'b0, 32'h80AD_BEEF, 16'hA566});
        vq.push_back('{1, 32'h20,   32'h0,         4'b0111, 3, 1'b0, 32'h8001_0000, 16'hA566});

        // clock/reset
        repeat (2) @(posedge clk);
        #1;
        check("reset_read_data", read_data, 32'h0);
        check("reset_clk_stall", 32'(clk_stall), 32'h0);
        check("reset_led", 32'(led), 32'h0);
        check("reset_access_err", 32'(access_err), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            do_access(vq[i].op, vq[i].a, vq[i].wd, vq[i].sm, st, e);
            check($sformatf("row%0d_stall", i), 32'(st), 32'(vq[i].stalls));
            check($sformatf("row%0d_err", i), 32'(e), 32'(vq[i].err));
            if (vq[i].err) begin
                @(posedge clk);
                #1;
                check($sformatf("row%0d_err_pulse", i), 32'(access_err), 32'h0);
            end
            check($sformatf("row%0d_rd", i), read_data, vq[i].rd);
            check($sformatf("row%0d_led", i), 32'(led), 32'(vq[i].led_v));
        end

        // Reset while a store sits in WRITE must abort it.
        do_access(0, 32'h30, 32'hAAAA_5555, 4'b0111, st, e);
        check("t6_prior_store_stall", 32'(st), 32'd3);
        @(negedge clk);
        addr       = 32'h30;
        write_data = 32'h1234_5678;
        sign_mask  = 4'b0111;
        memwrite   = 1'b1;
        @(posedge clk);
        #1;
        memwrite = 1'b0;
        check("t6_stall_raised", 32'(clk_stall), 32'h1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t6_reset_stall", 32'(clk_stall), 32'h0);
        check("t6_reset_read_data", read_data, 32'h0);
        check("t6_reset_led", 32'(led), 32'h0);
        check("t6_reset_err", 32'(access_err), 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        do_access(1, 32'h30, 32'h0, 4'b0111, st, e);
        check("t6_reload_stall", 32'(st), 32'd3);
        check("t6_reload_data", read_data, 32'hAAAA_5555);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
